riscv_mcycle_ctrl: RTL and testbench

- Multicycle control FSM that sequences a shared-memory RV32I datapath: PC register, instruction register, regfile, extend unit, ALU, ALU-result and data registers.
- One instruction takes 3-5 states, plus wait states for memory.
- Decodes lw, sw, R-type ALU, I-type ALU, beq and jal. Drives every datapath enable and mux select.
- Traps on anything else.

---
 rtl/riscv_mcycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_riscv_mcycle_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mcycle_ctrl.sv
`default_nettype none
// riscv_mcycle_ctrl: multicycle control FSM for a shared-memory RV32I datapath.
// Revision: 1.0 - lw/sw/R/I/beq/jal sequencing with sticky illegal-instruction trap.
module riscv_mcycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ctrl,
  output logic [1:0] result_src,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [1:0] c_ALU_ADD = 2'd0;
  localparam logic [1:0] c_ALU_SUB = 2'd1;
  localparam logic [1:0] c_ALU_AND = 2'd2;
  localparam logic [1:0] c_ALU_OR  = 2'd3;

  state_t state_q, state_d;
  logic   illegal_q;

  logic w_is_lw, w_is_sw, w_is_r, w_is_i, w_is_br, w_is_jal;
  logic w_alu_ok;
  logic [1:0] w_alu_fn;

  assign w_is_lw  = (op == 7'b0000011);
  assign w_is_sw  = (op == 7'b0100011);
  assign w_is_r   = (op == 7'b0110011);
  assign w_is_i   = (op == 7'b0010011);
  assign w_is_br  = (op == 7'b1100011);
  assign w_is_jal = (op == 7'b1101111);

  // Only add/sub, or, and are implemented; funct7_5 selects sub for R-type only.
  assign w_alu_ok = ((funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111)) &&
                    !(w_is_r && funct7_5 && (funct3 != 3'b000));

  always_comb begin
    case (funct3)
      3'b110:  w_alu_fn = c_ALU_OR;
      3'b111:  w_alu_fn = c_ALU_AND;
      default: w_alu_fn = (w_is_r && funct7_5) ? c_ALU_SUB : c_ALU_ADD;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    adr_src    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    imm_src    = 2'd0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_ctrl   = c_ALU_ADD;
    result_src = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          alu_src_b  = 2'd2;
          result_src = 2'd2;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        imm_src   = w_is_jal ? 2'd3 : 2'd2;
        if (w_is_lw || w_is_sw)             state_d = S_MEMADR;
        else if (w_is_r)                    state_d = w_alu_ok ? S_EXEC_R : S_TRAP;
        else if (w_is_i)                    state_d = w_alu_ok ? S_EXEC_I : S_TRAP;
        else if (w_is_br && funct3 == 3'b0) state_d = S_BEQ;
        else if (w_is_jal)                  state_d = S_JAL;
        else                                state_d = S_TRAP;
      end
      S_MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        imm_src   = w_is_sw ? 2'd1 : 2'd0;
        state_d   = w_is_sw ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'd1;
        reg_we     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 2'd2;
        alu_ctrl  = w_alu_fn;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        alu_ctrl  = w_alu_fn;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'd2;
        alu_ctrl  = c_ALU_SUB;
        pc_we     = alu_zero;
        state_d   = S_FETCH;
      end
      // PC takes the target latched in DECODE while the ALU computes old PC+4 for rd.
      S_JAL: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        pc_we     = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= state_t'(RESET_STATE);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mcycle_ctrl.sv
`default_nettype none
// tb_riscv_mcycle_ctrl: per-cycle scoreboard check of state and all control outputs.
module tb_riscv_mcycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_we, adr_src, mem_req, mem_we, ir_we, reg_we, illegal;
  logic [1:0] imm_src, alu_src_a, alu_src_b, alu_ctrl, result_src;
  logic [3:0] state;

  riscv_mcycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_we(pc_we), .adr_src(adr_src),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .reg_we(reg_we),
    .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .result_src(result_src), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  logic [20:0] w_got;
  assign w_got = {state, pc_we, adr_src, mem_req, mem_we, ir_we, reg_we,
                  imm_src, alu_src_a, alu_src_b, alu_ctrl, result_src, illegal};

  logic [20:0] sb [$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [20:0] ev(input int st, pw, as, rq, mw, iw, rw,
                                     input int imm, a, b, alu, res, il);
    return {st[3:0], pw[0], as[0], rq[0], mw[0], iw[0], rw[0],
            imm[1:0], a[1:0], b[1:0], alu[1:0], res[1:0], il[0]};
  endfunction

  logic [20:0] e_frdy, e_fidle, e_dec2, e_dec3, e_madr_l, e_madr_s, e_mrd, e_mwb;
  logic [20:0] e_mwr, e_xr_sub, e_xi_or, e_awb, e_beq1, e_beq0, e_jal, e_trap;

  task automatic test_reset();
    logic [23:0] t [2];
    logic [20:0] got, exp;
    t = '{{3'b000, e_fidle}, {3'b000, e_fidle}};
    foreach (t[i]) begin
      {rst, alu_zero, mem_ready} = t[i][23:21];
      sb.push_back(t[i][20:0]);
      @(negedge clk);
      got = w_got; exp = sb.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL reset cyc%0d: got %h expected %h", i, got, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    logic [23:0] t [8];
    logic [20:0] got, exp;
    op = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    t = '{{3'b001, e_frdy}, {3'b001, e_dec2}, {3'b001, e_madr_l}, {3'b000, e_mrd},
          {3'b000, e_mrd}, {3'b001, e_mrd}, {3'b001, e_mwb}, {3'b000, e_fidle}};
    foreach (t[i]) begin
      {rst, alu_zero, mem_ready} = t[i][23:21];
      sb.push_back(t[i][20:0]);
      @(negedge clk);
      got = w_got; exp = sb.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL lw cyc%0d: got %h expected %h", i, got, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [23:0] t [5];
    logic [20:0] got, exp;
    op = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0;
    t = '{{3'b001, e_frdy}, {3'b001, e_dec2}, {3'b001, e_madr_s}, {3'b001, e_mwr},
          {3'b000, e_fidle}};
    foreach (t[i]) begin
      {rst, alu_zero, mem_ready} = t[i][23:21];
      sb.push_back(t[i][20:0]);
      @(negedge clk);
      got = w_got; exp = sb.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL sw cyc%0d: got %h expected %h", i, got, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    logic [23:0] t [10];
    logic [20:0] got, exp;
    t = '{{3'b001, e_frdy}, {3'b001, e_dec2}, {3'b001, e_xr_sub}, {3'b001, e_awb},
          {3'b000, e_fidle},
          {3'b001, e_frdy}, {3'b001, e_dec2}, {3'b001, e_xi_or}, {3'b001, e_awb},
          {3'b000, e_fidle}};
    foreach (t[i]) begin
      if (i < 5) begin op = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1; end
      else       begin op = 7'b0010011; funct3 = 3'b110; funct7_5 = 1'b1; end
      {rst, alu_zero, mem_ready} = t[i][23:21];
      sb.push_back(t[i][20:0]);
      @(negedge clk);
      got = w_got; exp = sb.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL alu cyc%0d: got %h expected %h", i, got, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [23:0] t [8];
    logic [20:0] got, exp;
    op = 7'b1100011; funct3 = 3'b000; funct7_5 = 1'b0;
    t = '{{3'b001, e_frdy}, {3'b001, e_dec2}, {3'b011, e_beq1}, {3'b000, e_fidle},
          {3'b001, e_frdy}, {3'b011, e_dec2}, {3'b001, e_beq0}, {3'b000, e_fidle}};
    foreach (t[i]) begin
      {rst, alu_zero, mem_ready} = t[i][23:21];
      sb.push_back(t[i][20:0]);
      @(negedge clk);
      got = w_got; exp = sb.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL beq cyc%0d: got %h expected %h", i, got, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jal();
    logic [23:0] t [5];
    logic [20:0] got, exp;
    op = 7'b1101111; funct3 = 3'b101; funct7_5 = 1'b1;
    t = '{{3'b001, e_frdy}, {3'b001, e_dec3}, {3'b001, e_jal}, {3'b001, e_awb},
          {3'b000, e_fidle}};
    foreach (t[i]) begin
      {rst, alu_zero, mem_ready} = t[i][23:21];
      sb.push_back(t[i][20:0]);
      @(negedge clk);
      got = w_got; exp = sb.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL jal cyc%0d: got %h expected %h", i, got, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap();
    logic [23:0] t [14];
    logic [20:0] got, exp;
    op = 7'b1110011; funct3 = 3'b000; funct7_5 = 1'b0;
    t[0] = {3'b001, e_frdy};
    t[1] = {3'b001, e_dec2};
    for (int k = 2; k < 12; k++) t[k] = {3'b001, e_trap};
    t[12] = {3'b100, e_trap};
    t[13] = {3'b000, e_fidle};
    foreach (t[i]) begin
      {rst, alu_zero, mem_ready} = t[i][23:21];
      sb.push_back(t[i][20:0]);
      @(negedge clk);
      got = w_got; exp = sb.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL trap cyc%0d: got %h expected %h", i, got, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_illegal();
    logic [23:0] t [10];
    logic [20:0] got, exp;
    t = '{{3'b001, e_frdy}, {3'b001, e_dec2}, {3'b001, e_trap}, {3'b100, e_trap},
          {3'b000, e_fidle},
          {3'b001, e_frdy}, {3'b001, e_dec2}, {3'b001, e_trap}, {3'b100, e_trap},
          {3'b000, e_fidle}};
    foreach (t[i]) begin
      if (i < 5) begin op = 7'b0110011; funct3 = 3'b001; funct7_5 = 1'b0; end
      else       begin op = 7'b0110011; funct3 = 3'b110; funct7_5 = 1'b1; end
      {rst, alu_zero, mem_ready} = t[i][23:21];
      sb.push_back(t[i][20:0]);
      @(negedge clk);
      got = w_got; exp = sb.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL alu_illegal cyc%0d: got %h expected %h", i, got, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_memread();
    logic [23:0] t [5];
    logic [20:0] got, exp;
    op = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    t = '{{3'b001, e_frdy}, {3'b001, e_dec2}, {3'b001, e_madr_l}, {3'b100, e_mrd},
          {3'b000, e_fidle}};
    foreach (t[i]) begin
      {rst, alu_zero, mem_ready} = t[i][23:21];
      sb.push_back(t[i][20:0]);
      @(negedge clk);
      got = w_got; exp = sb.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL reset_memread cyc%0d: got %h expected %h", i, got, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    //             st pw as rq mw iw rw imm a b alu res il
    e_frdy   = ev(0, 1, 0, 1, 0, 1, 0, 0, 0, 2, 0, 2, 0);
    e_fidle  = ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_dec2   = ev(1, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    e_dec3   = ev(1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    e_madr_l = ev(2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    e_madr_s = ev(2, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0);
    e_mrd    = ev(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_mwb    = ev(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    e_mwr    = ev(5, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    e_xr_sub = ev(6, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0);
    e_xi_or  = ev(7, 0, 0, 0, 0, 0, 0, 0, 2, 1, 3, 0, 0);
    e_awb    = ev(8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    e_beq1   = ev(9, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0);
    e_beq0   = ev(9, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0);
    e_jal    = ev(10, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    e_trap   = ev(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_sw();
    test_alu();
    test_beq();
    test_jal();
    test_trap();
    test_alu_illegal();
    test_reset_memread();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
